// File: rtl/ysyx_23060124_pipe_stage_reg_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers.
// Stage wrappers import the occupancy encodings from here.
package ysyx_23060124_pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/ysyx_23060124_pipe_stage_reg.sv
// Generic valid/ready pipeline register with optional skid entry, synchronous flush
// and optional zeroed bubbles. o_count mirrors the occupancy state encoding.
module ysyx_23060124_pipe_stage_reg
  import ysyx_23060124_pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SKID        = 1,
  parameter int unsigned ZERO_BUBBLE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_pre_valid,
  output logic              o_pre_ready,
  input  logic [DATA_W-1:0] i_pre_data,
  output logic              o_post_valid,
  input  logic              i_post_ready,
  output logic [DATA_W-1:0] o_post_data,
  output logic [1:0]        o_count
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              accept, consume;

  assign accept       = i_pre_valid & o_pre_ready;
  assign consume      = o_post_valid & i_post_ready;
  assign o_post_valid = (state_q != PIPE_EMPTY);
  assign o_post_data  = main_q;
  assign o_count      = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= PIPE_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q;

    // Ready is registered from the next state so no comb path reaches upstream.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        skid_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        skid_q  <= skid_d;
        ready_q <= (state_d != PIPE_TWO);
      end
    end

    assign o_pre_ready = ready_q;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (i_flush) begin
        state_d = PIPE_EMPTY;
        if (ZERO_BUBBLE != 0) begin
          main_d = '0;
          skid_d = '0;
        end
      end else begin
        case (state_q)
          PIPE_EMPTY: begin
            if (accept) begin
              state_d = PIPE_ONE;
              main_d  = i_pre_data;
            end
          end
          PIPE_ONE: begin
            if (accept && consume) begin
              main_d = i_pre_data;
            end else if (accept) begin
              state_d = PIPE_TWO;
              skid_d  = i_pre_data;
            end else if (consume) begin
              state_d = PIPE_EMPTY;
              if (ZERO_BUBBLE != 0) main_d = '0;
            end
          end
          PIPE_TWO: begin
            if (consume) begin
              state_d = PIPE_ONE;
              main_d  = skid_q;
              if (ZERO_BUBBLE != 0) skid_d = '0;
            end
          end
          default: state_d = PIPE_EMPTY;
        endcase
      end
    end
  end else begin : g_single
    assign o_pre_ready = (state_q == PIPE_EMPTY) | i_post_ready;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (i_flush) begin
        state_d = PIPE_EMPTY;
        if (ZERO_BUBBLE != 0) main_d = '0;
      end else begin
        case (state_q)
          PIPE_EMPTY: begin
            if (accept) begin
              state_d = PIPE_ONE;
              main_d  = i_pre_data;
            end
          end
          PIPE_ONE: begin
            if (accept) begin
              main_d = i_pre_data;
            end else if (consume) begin
              state_d = PIPE_EMPTY;
              if (ZERO_BUBBLE != 0) main_d = '0;
            end
          end
          default: state_d = PIPE_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_pipe_stage_reg.sv
// Bench for the pipeline stage register: directed SKID=1 scenarios plus random
// SKID=0 traffic, checked by a negedge scoreboard monitor.
module tb_ysyx_23060124_pipe_stage_reg;

  logic        clock = 1'b0;
  logic        reset;

  logic        a_flush, a_pre_valid, a_pre_ready, a_post_valid, a_post_ready;
  logic [31:0] a_pre_data, a_post_data;
  logic [1:0]  a_count;

  logic        b_flush, b_pre_valid, b_pre_ready, b_post_valid, b_post_ready;
  logic [31:0] b_pre_data, b_post_data;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_q[$];
  logic [31:0] b_q[$];

  always #5 clock = ~clock;

  ysyx_23060124_pipe_stage_reg #(.DATA_W(32), .SKID(1), .ZERO_BUBBLE(1)) dut_a (
    .clock(clock), .reset(reset), .i_flush(a_flush),
    .i_pre_valid(a_pre_valid), .o_pre_ready(a_pre_ready), .i_pre_data(a_pre_data),
    .o_post_valid(a_post_valid), .i_post_ready(a_post_ready), .o_post_data(a_post_data),
    .o_count(a_count)
  );

  ysyx_23060124_pipe_stage_reg #(.DATA_W(32), .SKID(0), .ZERO_BUBBLE(1)) dut_b (
    .clock(clock), .reset(reset), .i_flush(b_flush),
    .i_pre_valid(b_pre_valid), .o_pre_ready(b_pre_ready), .i_pre_data(b_pre_data),
    .o_post_valid(b_post_valid), .i_post_ready(b_post_ready), .o_post_data(b_post_data),
    .o_count(b_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [31:0] d,
                       input logic [1:0] c, input logic r);
    chk({tag, "_valid"}, 32'(a_post_valid), 32'(v));
    chk({tag, "_data"},  a_post_data, d);
    chk({tag, "_count"}, 32'(a_count), 32'(c));
    chk({tag, "_ready"}, 32'(a_pre_ready), 32'(r));
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (!reset) begin
        a_q.delete();
        b_q.delete();
      end else begin
        if (a_post_valid && a_post_ready) begin
          if (a_q.size() == 0) chk("a_unexpected_beat", a_post_data, 32'hdead_beef);
          else chk("a_sb_data", a_post_data, a_q.pop_front());
        end
        if (a_pre_valid && a_pre_ready && !a_flush) a_q.push_back(a_pre_data);
        if (a_flush) a_q.delete();

        if (b_post_ready) chk("b_ready_rule", 32'(b_pre_ready), 32'd1);
        if (b_post_valid && b_post_ready) begin
          if (b_q.size() == 0) chk("b_unexpected_beat", b_post_data, 32'hdead_beef);
          else chk("b_sb_data", b_post_data, b_q.pop_front());
        end
        if (b_pre_valid && b_pre_ready && !b_flush) b_q.push_back(b_pre_data);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    a_flush = 1'b0; a_pre_valid = 1'b1; a_pre_data = 32'h5a5a_5a5a; a_post_ready = 1'b0;
    b_flush = 1'b0; b_pre_valid = 1'b1; b_pre_data = 32'h1234_5678; b_post_ready = 1'b0;
    fork
      monitor();
    join_none

    // Reset held with upstream valid asserted
    repeat (3) step();
    chk_a("rst", 1'b0, 32'h0, 2'd0, 1'b1);
    chk("rst_b_valid", 32'(b_post_valid), 32'd0);
    chk("rst_b_ready", 32'(b_pre_ready), 32'd1);
    reset = 1'b1;
    a_pre_valid = 1'b0;
    b_pre_valid = 1'b0;
    step();

    // Streaming 0x1..0x8 at full throughput
    a_post_ready = 1'b1;
    for (int unsigned i = 1; i <= 8; i++) begin
      a_pre_valid = 1'b1;
      a_pre_data  = 32'(i);
      step();
      chk_a("stream", 1'b1, 32'(i), 2'd1, 1'b1);
    end
    a_pre_valid = 1'b0;
    step();
    chk_a("stream_end", 1'b0, 32'h0, 2'd0, 1'b1);

    // Backpressure fills the skid entry
    a_post_ready = 1'b0;
    a_pre_valid = 1'b1; a_pre_data = 32'hA;
    step();
    chk_a("bp_one", 1'b1, 32'hA, 2'd1, 1'b1);
    a_pre_data = 32'hB;
    step();
    a_pre_valid = 1'b0;
    chk_a("bp_two", 1'b1, 32'hA, 2'd2, 1'b0);
    step();
    chk_a("bp_hold", 1'b1, 32'hA, 2'd2, 1'b0);
    a_post_ready = 1'b1;
    step();
    chk_a("bp_rel1", 1'b1, 32'hB, 2'd1, 1'b1);
    step();
    chk_a("bp_rel2", 1'b0, 32'h0, 2'd0, 1'b1);

    // Flush with both entries held; 0xC offered but stage is full
    a_post_ready = 1'b0;
    a_pre_valid = 1'b1; a_pre_data = 32'h11;
    step();
    a_pre_data = 32'h22;
    step();
    chk_a("fl_full", 1'b1, 32'h11, 2'd2, 1'b0);
    a_flush = 1'b1; a_pre_data = 32'hC;
    step();
    a_flush = 1'b0; a_pre_valid = 1'b0;
    chk_a("fl_two", 1'b0, 32'h0, 2'd0, 1'b1);

    // Flush with one entry while 0xC is actually accepted: 0xC must vanish
    a_pre_valid = 1'b1; a_pre_data = 32'h33;
    step();
    a_flush = 1'b1; a_pre_data = 32'hC;
    step();
    a_flush = 1'b0; a_pre_valid = 1'b0;
    chk_a("fl_one", 1'b0, 32'h0, 2'd0, 1'b1);
    a_post_ready = 1'b1;
    step();
    step();
    chk_a("fl_after", 1'b0, 32'h0, 2'd0, 1'b1);

    // Asynchronous reset between edges with two beats held
    a_post_ready = 1'b0;
    a_pre_valid = 1'b1; a_pre_data = 32'h44;
    step();
    a_pre_data = 32'h55;
    step();
    a_pre_valid = 1'b0;
    chk_a("ar_full", 1'b1, 32'h44, 2'd2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_a("ar_now", 1'b0, 32'h0, 2'd0, 1'b1);
    step();
    reset = 1'b1;
    a_post_ready = 1'b1;
    repeat (3) step();
    chk_a("ar_after", 1'b0, 32'h0, 2'd0, 1'b1);

    // SKID=0 random traffic against the scoreboard
    for (int unsigned i = 0; i < 1000; i++) begin
      b_pre_valid  = 1'($urandom_range(0, 1));
      b_pre_data   = $urandom;
      b_post_ready = 1'($urandom_range(0, 1));
      step();
    end
    b_pre_valid  = 1'b0;
    b_post_ready = 1'b1;
    repeat (3) step();
    chk("b_drain_queue", 32'(b_q.size()), 32'd0);
    chk("b_drain_count", 32'(b_count), 32'd0);
    chk("a_drain_queue", 32'(a_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
